// File: rtl/cpu_mem_responder_if.sv
// Core-to-memory bus for the instruction port and the load/store port.
// master = core side, slave = memory responder side.
interface cpu_mem_responder_if #(
    parameter int IW = 32
);
    logic [IW-1:0] i_pc_addr;
    logic          i_pc_rd;
    logic [3:0]    i_pc_byte_en;
    logic [IW-1:0] o_pc_rddata;

    logic [IW-1:0] i_ldst_addr;
    logic          i_ldst_rd;
    logic          i_ldst_wr;
    logic [IW-1:0] i_ldst_wrdata;
    logic [3:0]    i_ldst_byte_en;
    logic [IW-1:0] o_ldst_rddata;

    logic          o_misalign;
    logic          o_bus_err;
    logic          o_halt;
    logic [IW-1:0] o_tohost;

    modport master (
        output i_pc_addr, i_pc_rd, i_pc_byte_en,
        output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_ldst_byte_en,
        input  o_pc_rddata, o_ldst_rddata, o_misalign, o_bus_err, o_halt, o_tohost
    );

    modport slave (
        input  i_pc_addr, i_pc_rd, i_pc_byte_en,
        input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_ldst_byte_en,
        output o_pc_rddata, o_ldst_rddata, o_misalign, o_bus_err, o_halt, o_tohost
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Shared word RAM + MMIO (cycle counter, tohost/halt) serving the core's fetch and load/store ports.
// Fixed 1-cycle read latency on both ports; no backpressure, every strobe is served the cycle it is presented.
module cpu_mem_responder #(
    parameter int              IW          = 32,
    parameter int              DEPTH_WORDS = 8192,
    parameter logic [IW-1:0]   MMIO_BASE   = 32'hFFFF_0000,
    parameter string           INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              reset,
    cpu_mem_responder_if.slave bus
);
    localparam int            AW          = $clog2(DEPTH_WORDS);
    localparam logic [IW-1:0] RAM_BYTES   = IW'(DEPTH_WORDS) << 2;
    localparam logic [IW-1:0] TOHOST_ADDR = MMIO_BASE + IW'(4);

    logic [IW-1:0] mem [DEPTH_WORDS];
    logic [IW-1:0] cycle_cnt;

    // Instruction port decode: alignment faults take precedence over address faults.
    logic [AW-1:0] pc_idx;
    logic          pc_mis;
    logic          pc_berr;

    assign pc_idx  = bus.i_pc_addr[AW+1:2];
    assign pc_mis  = bus.i_pc_rd &&
                     (bus.i_pc_addr[1:0] != 2'b00 || bus.i_pc_byte_en != 4'b1111);
    assign pc_berr = bus.i_pc_rd && !pc_mis && (bus.i_pc_addr >= RAM_BYTES);

    // Load/store port decode.
    logic [AW-1:0] ls_idx;
    logic [1:0]    ls_off;
    logic          ls_req;
    logic          size_ok;
    logic          in_ram;
    logic          is_cnt;
    logic          is_th;
    logic          ls_mis;
    logic          ls_berr;
    logic          rd_only;
    logic          st_we;
    logic          th_we;
    logic [3:0]    lane;
    logic [IW-1:0] wdat;
    logic [IW-1:0] ld_src;
    logic [IW-1:0] ld_mask;
    logic [IW-1:0] ld_val;

    assign ls_idx  = bus.i_ldst_addr[AW+1:2];
    assign ls_off  = bus.i_ldst_addr[1:0];
    assign ls_req  = bus.i_ldst_rd || bus.i_ldst_wr;
    assign rd_only = bus.i_ldst_rd && !bus.i_ldst_wr;
    assign in_ram  = bus.i_ldst_addr < RAM_BYTES;
    assign is_cnt  = bus.i_ldst_addr == MMIO_BASE;
    assign is_th   = bus.i_ldst_addr == TOHOST_ADDR;

    always_comb begin
        size_ok = 1'b0;
        ld_mask = '0;
        case (bus.i_ldst_byte_en)
            4'b0001: begin size_ok = 1'b1;             ld_mask = IW'(8'hFF);   end
            4'b0011: begin size_ok = !ls_off[0];       ld_mask = IW'(16'hFFFF); end
            4'b1111: begin size_ok = (ls_off == 2'b00); ld_mask = '1;           end
            default: begin size_ok = 1'b0;             ld_mask = '0;           end
        endcase
    end

    // A simultaneous rd+wr still performs a legal write; only the read is dropped and flagged.
    assign ls_mis  = (ls_req && !size_ok) ||
                     (bus.i_ldst_rd && bus.i_ldst_wr) ||
                     (bus.i_ldst_wr && size_ok && is_th && bus.i_ldst_byte_en != 4'b1111);
    assign ls_berr = ls_req && size_ok &&
                     (!(in_ram || is_cnt || is_th) || (bus.i_ldst_wr && is_cnt));
    assign st_we   = bus.i_ldst_wr && size_ok && in_ram;
    assign th_we   = bus.i_ldst_wr && size_ok && is_th && bus.i_ldst_byte_en == 4'b1111;

    assign lane    = bus.i_ldst_byte_en << ls_off;
    assign wdat    = bus.i_ldst_wrdata << {ls_off, 3'b000};
    assign ld_src  = in_ram ? mem[ls_idx] : (is_cnt ? cycle_cnt : '0);
    assign ld_val  = (ld_src >> {ls_off, 3'b000}) & ld_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.o_pc_rddata   <= '0;
            bus.o_ldst_rddata <= '0;
            bus.o_misalign    <= 1'b0;
            bus.o_bus_err     <= 1'b0;
            bus.o_halt        <= 1'b0;
            bus.o_tohost      <= '0;
            cycle_cnt         <= '0;
        end else begin
            cycle_cnt      <= cycle_cnt + IW'(1);
            bus.o_misalign <= pc_mis || ls_mis;
            bus.o_bus_err  <= pc_berr || ls_berr;
            if (bus.i_pc_rd)
                bus.o_pc_rddata <= (pc_mis || pc_berr) ? '0 : mem[pc_idx];
            if (rd_only)
                bus.o_ldst_rddata <= (ls_mis || ls_berr) ? '0 : ld_val;
            if (th_we) begin
                bus.o_tohost <= bus.i_ldst_wrdata;
                bus.o_halt   <= 1'b1;
            end
        end
    end

    // Non-blocking update gives the fetch port the pre-write word on a same-word collision.
    always_ff @(posedge clk) begin
        if (!reset && st_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane[b])
                    mem[ls_idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: byte-array reference model checked every cycle,
// plus literal expectations from the worked examples.
module tb_cpu_mem_responder;
    localparam int          IW = 32;
    localparam int          DW = 256;
    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_mem_responder_if #(.IW(IW)) bus();

    cpu_mem_responder #(
        .IW(IW), .DEPTH_WORDS(DW), .MMIO_BASE(MB), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as bytes, outputs derived from the access rules.
    logic [7:0]  mm [0:DW*4-1];
    logic [31:0] e_pc, e_ld, e_tohost, m_cnt;
    logic        e_mis, e_berr, e_halt;
    bit          model_ok = 0;

    always @(posedge clk) begin : model
        int          sz;
        logic        mis, berr, bad;
        logic [31:0] a, v, wd;
        model_ok = 1;
        if (reset) begin
            e_pc = 0; e_ld = 0; e_mis = 0; e_berr = 0;
            e_halt = 0; e_tohost = 0; m_cnt = 0;
        end else begin
            mis = 0; berr = 0;
            if (bus.i_pc_rd) begin
                a = bus.i_pc_addr;
                if (a % 4 != 0 || bus.i_pc_byte_en != 4'hF) begin mis = 1; e_pc = 0; end
                else if (a >= DW*4) begin berr = 1; e_pc = 0; end
                else e_pc = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
            end
            a  = bus.i_ldst_addr;
            wd = bus.i_ldst_wrdata;
            sz = (bus.i_ldst_byte_en == 4'h1) ? 1 : (bus.i_ldst_byte_en == 4'h3) ? 2 :
                 (bus.i_ldst_byte_en == 4'hF) ? 4 : 0;
            bad = (sz == 0) || (a % sz != 0);
            if (bus.i_ldst_rd || bus.i_ldst_wr) begin
                if (bad) mis = 1;
                if (bus.i_ldst_rd && bus.i_ldst_wr) mis = 1;
                if (bus.i_ldst_rd && !bus.i_ldst_wr) begin
                    v = 0;
                    if (bad) v = 0;
                    else if (a < DW*4) for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[a+i];
                    else if (a == MB) for (int i = 0; i < sz; i++) v[8*i +: 8] = m_cnt[8*i +: 8];
                    else if (a == MB + 4) v = 0;
                    else berr = 1;
                    e_ld = v;
                end
                if (bus.i_ldst_wr && !bad) begin
                    if (a < DW*4) for (int i = 0; i < sz; i++) mm[a+i] = wd[8*i +: 8];
                    else if (a == MB + 4) begin
                        if (sz == 4) begin e_tohost = wd; e_halt = 1; end
                        else mis = 1;
                    end
                    else berr = 1;
                end
            end
            m_cnt++;
            e_mis  = mis;
            e_berr = berr;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("cmp pc_rddata",   bus.o_pc_rddata,   e_pc);
            chk("cmp ldst_rddata", bus.o_ldst_rddata, e_ld);
            chk("cmp misalign",    32'(bus.o_misalign), 32'(e_mis));
            chk("cmp bus_err",     32'(bus.o_bus_err),  32'(e_berr));
            chk("cmp halt",        32'(bus.o_halt),     32'(e_halt));
            chk("cmp tohost",      bus.o_tohost,      e_tohost);
        end
    end

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                       input logic [31:0] exp);
        chk(name, act, exp);
        chk({name, " (model)"}, mdl, exp);
    endtask

    task automatic cyc(input logic prd, input logic [31:0] pa, input logic [3:0] pbe,
                       input logic lrd, input logic lwr, input logic [31:0] la,
                       input logic [31:0] wd, input logic [3:0] lbe);
        bus.i_pc_rd = prd; bus.i_pc_addr = pa; bus.i_pc_byte_en = pbe;
        bus.i_ldst_rd = lrd; bus.i_ldst_wr = lwr; bus.i_ldst_addr = la;
        bus.i_ldst_wrdata = wd; bus.i_ldst_byte_en = lbe;
        @(posedge clk);
        #1;
        bus.i_pc_rd = 1'b0; bus.i_ldst_rd = 1'b0; bus.i_ldst_wr = 1'b0;
    endtask

    task automatic pc(input logic [31:0] a);
        cyc(1, a, 4'hF, 0, 0, 0, 0, 4'hF);
    endtask
    task automatic ld(input logic [31:0] a, input logic [3:0] be);
        cyc(0, 0, 4'hF, 1, 0, a, 0, be);
    endtask
    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(0, 0, 4'hF, 0, 1, a, d, be);
    endtask
    task automatic idle();
        cyc(0, 0, 4'hF, 0, 0, 0, 0, 4'hF);
    endtask

    initial begin
        reset = 1'b1;
        bus.i_pc_addr = 0; bus.i_pc_rd = 0; bus.i_pc_byte_en = 4'hF;
        bus.i_ldst_addr = 0; bus.i_ldst_rd = 0; bus.i_ldst_wr = 0;
        bus.i_ldst_wrdata = 0; bus.i_ldst_byte_en = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        lit("reset pc_rddata",   bus.o_pc_rddata,   e_pc,   0);
        lit("reset ldst_rddata", bus.o_ldst_rddata, e_ld,   0);
        lit("reset misalign",    32'(bus.o_misalign), 32'(e_mis),  0);
        lit("reset bus_err",     32'(bus.o_bus_err),  32'(e_berr), 0);
        lit("reset halt",        32'(bus.o_halt),     32'(e_halt), 0);
        lit("reset tohost",      bus.o_tohost,      e_tohost, 0);
        reset = 1'b0;

        st(0, 32'h0000_0013, 4'hF);
        st(4, 32'h0010_0093, 4'hF);
        st(8, 32'hDEAD_BEEF, 4'hF);
        st(12, 32'h1234_5678, 4'hF);
        pc(0);  lit("fetch 0", bus.o_pc_rddata, e_pc, 32'h0000_0013);
        pc(4);  lit("fetch 4", bus.o_pc_rddata, e_pc, 32'h0010_0093);
        pc(8);  lit("fetch 8", bus.o_pc_rddata, e_pc, 32'hDEAD_BEEF);
        idle(); lit("fetch hold", bus.o_pc_rddata, e_pc, 32'hDEAD_BEEF);

        st(9, 32'hFFFF_FFAB, 4'h1);
        ld(8, 4'hF);  lit("lw 8 after sb", bus.o_ldst_rddata, e_ld, 32'hDEAD_ABEF);
        ld(11, 4'h1); lit("lbu 11", bus.o_ldst_rddata, e_ld, 32'h0000_00DE);
        ld(10, 4'h3); lit("lhu 10", bus.o_ldst_rddata, e_ld, 32'h0000_DEAD);

        st(5, 32'h0000_FFFF, 4'h3); lit("sh 5 misalign", 32'(bus.o_misalign), 32'(e_mis), 1);
        ld(4, 4'hF);  lit("word 1 unchanged", bus.o_ldst_rddata, e_ld, 32'h0010_0093);
        lit("misalign one cycle", 32'(bus.o_misalign), 32'(e_mis), 0);
        ld(2, 4'hF);  lit("lw 2 misalign", 32'(bus.o_misalign), 32'(e_mis), 1);
        lit("lw 2 data", bus.o_ldst_rddata, e_ld, 0);
        ld(1, 4'h7);  lit("bad byte_en", 32'(bus.o_misalign), 32'(e_mis), 1);
        pc(6);        lit("fetch 6 misalign", 32'(bus.o_misalign), 32'(e_mis), 1);
        lit("fetch 6 data", bus.o_pc_rddata, e_pc, 0);

        cyc(1, 12, 4'hF, 0, 1, 12, 32'hCAFE_F00D, 4'hF);
        lit("collision old word", bus.o_pc_rddata, e_pc, 32'h1234_5678);
        pc(12); lit("collision new word", bus.o_pc_rddata, e_pc, 32'hCAFE_F00D);

        ld(DW*4, 4'hF); lit("lw past ram bus_err", 32'(bus.o_bus_err), 32'(e_berr), 1);
        lit("lw past ram data", bus.o_ldst_rddata, e_ld, 0);
        st(DW*4-4, 32'hA5A5_5A5A, 4'hF);
        ld(DW*4-4, 4'hF); lit("last word", bus.o_ldst_rddata, e_ld, 32'hA5A5_5A5A);
        lit("last word no err", 32'(bus.o_bus_err), 32'(e_berr), 0);

        cyc(0, 0, 4'hF, 1, 1, 0, 32'h55, 4'hF);
        lit("rd+wr misalign", 32'(bus.o_misalign), 32'(e_mis), 1);
        lit("rd+wr holds", bus.o_ldst_rddata, e_ld, 32'hA5A5_5A5A);
        ld(0, 4'hF); lit("rd+wr wrote", bus.o_ldst_rddata, e_ld, 32'h0000_0055);

        st(MB + 4, 32'h9, 4'h1); lit("sb tohost misalign", 32'(bus.o_misalign), 32'(e_mis), 1);
        lit("sb tohost no halt", 32'(bus.o_halt), 32'(e_halt), 0);
        st(MB, 32'h7, 4'hF); lit("sw counter bus_err", 32'(bus.o_bus_err), 32'(e_berr), 1);
        pc(MB);        lit("fetch mmio bus_err", 32'(bus.o_bus_err), 32'(e_berr), 1);
        ld(MB + 4, 4'hF); lit("read tohost", bus.o_ldst_rddata, e_ld, 0);
        st(MB + 4, 32'h1, 4'hF);
        lit("halt set", 32'(bus.o_halt), 32'(e_halt), 1);
        lit("tohost", bus.o_tohost, e_tohost, 1);
        idle(); lit("halt sticky", 32'(bus.o_halt), 32'(e_halt), 1);

        cyc(1, 6, 4'hF, 1, 0, 2, 0, 4'hF);
        lit("dual err pulse", 32'(bus.o_misalign), 32'(e_mis), 1);
        idle(); lit("dual err single", 32'(bus.o_misalign), 32'(e_mis), 0);

        reset = 1'b1;
        st(0, 32'hBAD, 4'hF);
        lit("reset clears halt", 32'(bus.o_halt), 32'(e_halt), 0);
        lit("reset clears tohost", bus.o_tohost, e_tohost, 0);
        lit("reset clears pc", bus.o_pc_rddata, e_pc, 0);
        lit("reset clears ld", bus.o_ldst_rddata, e_ld, 0);
        reset = 1'b0;
        cyc(1, 0, 4'hF, 1, 0, MB, 0, 4'hF);
        lit("counter restart", bus.o_ldst_rddata, e_ld, 0);
        lit("fetch after reset", bus.o_pc_rddata, e_pc, 32'h0000_0055);
        repeat (3) idle();
        ld(MB, 4'hF); lit("counter at 4", bus.o_ldst_rddata, e_ld, 4);
        ld(0, 4'hF);  lit("reset write dropped", bus.o_ldst_rddata, e_ld, 32'h0000_0055);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
